// File: rtl/lim_inc_pkg.sv
// lim_inc_pkg: shared constants and helpers for the modulo-L digit incrementor.
//   LIM_INC_N / LIM_INC_L : default digit width and limit (decimal digit).
//   lim_wrap()            : wrap condition (a out of range, or a+ci reaches L),
//                           reusable by digit-chain blocks.
package lim_inc_pkg;

  localparam int LIM_INC_N = 4;
  localparam int LIM_INC_L = 10;

  // Operands are widened to 33 bits so a+ci cannot overflow for any N <= 31.
  function automatic logic lim_wrap(input logic [31:0] a, input logic ci,
                                    input logic [31:0] l);
    logic [32:0] aw, t, lw;
    aw = {1'b0, a};
    lw = {1'b0, l};
    t  = aw + {32'd0, ci};
    return (aw >= lw) || (t >= lw);
  endfunction

endpackage

// File: rtl/lim_inc_core.sv
// lim_inc_core: combinational modulo-L increment of one digit.
//   a   [N-1:0] in  : input digit
//   ci          in  : carry-in
//   sum [N-1:0] out : (a+ci) wrapped to 0 at L, or 0 if a is out of range
//   co          out : wrap / carry-out
module lim_inc_core
  import lim_inc_pkg::*;
#(
  parameter int N = LIM_INC_N,
  parameter int L = LIM_INC_L
) (
  input  logic [N-1:0] a,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);

  logic [N:0] t;

  // N+1 bits so a = 2^N-1, ci = 1 does not alias back to 0.
  assign t   = {1'b0, a} + {{N{1'b0}}, ci};
  assign co  = lim_wrap(32'(a), ci, 32'(L));
  assign sum = co ? '0 : t[N-1:0];

endmodule

// File: rtl/lim_inc.sv
// lim_inc: limited (modulo-L) incrementor with registered copy and sticky
// range-error flag.
//   clk           in  : rising-edge clock
//   rst_n         in  : synchronous active-low reset (registered outputs only)
//   a     [N-1:0] in  : input digit
//   ci            in  : carry-in
//   sum   [N-1:0] out : combinational result
//   co            out : combinational carry-out
//   sum_q [N-1:0] out : sum registered
//   co_q          out : co registered
//   err           out : sticky, set once an out-of-range a is sampled
// Build option: define LIM_INC_ERR_EN to implement err; otherwise err is 0
// and has no flop.
module lim_inc
  import lim_inc_pkg::*;
#(
  parameter int N = LIM_INC_N,
  parameter int L = LIM_INC_L
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co,
  output logic [N-1:0] sum_q,
  output logic         co_q,
  output logic         err
);

  generate
    if (N < 1 || N > 31) begin : g_bad_n
      $error("lim_inc: N must be in 1..31");
    end
    if (L < 2 || L > (1 << N)) begin : g_bad_l
      $error("lim_inc: L must satisfy 2 <= L <= 2^N");
    end
  endgenerate

  lim_inc_core #(.N(N), .L(L)) u_core (
    .a   (a),
    .ci  (ci),
    .sum (sum),
    .co  (co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum;
      co_q  <= co;
    end
  end

`ifdef LIM_INC_ERR_EN
  logic oor;
  assign oor = ({1'b0, a} >= (N+1)'(L));

  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err | oor;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lim_inc.sv
module tb_lim_inc;
  localparam int N = 4;
  localparam int L = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] a;
  logic         ci;
  logic [N-1:0] sum, sum_q;
  logic         co, co_q, err;

  int total = 0;
  int bad   = 0;

  // expected registered state
  int exp_sq;
  int exp_cq;
  int exp_err;

`ifdef LIM_INC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  lim_inc #(.N(N), .L(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .ci    (ci),
    .sum   (sum),
    .co    (co),
    .sum_q (sum_q),
    .co_q  (co_q),
    .err   (err)
  );

  always #5 clk = ~clk;

  // reference: integer digit arithmetic modulo L
  function automatic int ref_sum(int av, int cv);
    if (av >= L || av + cv >= L) return 0;
    return av + cv;
  endfunction

  function automatic int ref_co(int av, int cv);
    return (av >= L || av + cv >= L) ? 1 : 0;
  endfunction

  // one clock edge, advancing the model from the inputs held across it
  task automatic tick();
    int nsq, ncq, nerr;
    if (!rst_n) begin
      nsq = 0; ncq = 0; nerr = 0;
    end else begin
      nsq  = ref_sum(int'(a), int'(ci));
      ncq  = ref_co(int'(a), int'(ci));
      nerr = (ERR_EN && (exp_err == 1 || int'(a) >= L)) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    exp_sq = nsq; exp_cq = ncq; exp_err = nerr;
  endtask

  task automatic chk_comb(string nm);
    total++;
    if (sum !== N'(ref_sum(int'(a), int'(ci))) || co !== 1'(ref_co(int'(a), int'(ci)))) begin
      bad++;
      $display("FAIL %s comb a=%0d ci=%0d: got sum=%0d co=%0b want sum=%0d co=%0d",
               nm, a, ci, sum, co, ref_sum(int'(a), int'(ci)), ref_co(int'(a), int'(ci)));
    end
  endtask

  task automatic chk_reg(string nm);
    total++;
    if (sum_q !== N'(exp_sq) || co_q !== 1'(exp_cq) || err !== 1'(exp_err)) begin
      bad++;
      $display("FAIL %s reg: got sum_q=%0d co_q=%0b err=%0b want sum_q=%0d co_q=%0d err=%0d",
               nm, sum_q, co_q, err, exp_sq, exp_cq, exp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a = 4'd5; ci = 1'b0;
    tick(); tick();
    total++;
    if (sum_q !== 4'd0 || co_q !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: got sum_q=%0d co_q=%0b err=%0b want 0 0 0", sum_q, co_q, err);
    end
    total++;
    if (sum !== 4'd5 || co !== 1'b0) begin
      bad++;
      $display("FAIL reset_comb: got sum=%0d co=%0b want 5 0", sum, co);
    end
  endtask

  task automatic test_sweep();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 2; c++) begin
        a = N'(i); ci = 1'(c);
        #1;
        chk_comb("sweep");
      end
    end
  endtask

  task automatic test_boundary();
    a = 4'd6; ci = 1'b0; #1;
    total++;
    if (sum !== 4'd6 || co !== 1'b0) begin
      bad++; $display("FAIL bound_ci0: got sum=%0d co=%0b want 6 0", sum, co);
    end
    ci = 1'b1; #1;
    total++;
    if (sum !== 4'd0 || co !== 1'b1) begin
      bad++; $display("FAIL bound_ci1: got sum=%0d co=%0b want 0 1", sum, co);
    end
    a = 4'd15; ci = 1'b1; #1;
    total++;
    if (sum !== 4'd0 || co !== 1'b1) begin
      bad++; $display("FAIL oor_15: got sum=%0d co=%0b want 0 1", sum, co);
    end
  endtask

  task automatic test_registered();
    rst_n = 1'b0; tick();          // clear any err from earlier sweeps
    rst_n = 1'b1; a = 4'd3; ci = 1'b1;
    tick();
    total++;
    if (sum_q !== 4'd4 || co_q !== 1'b0) begin
      bad++; $display("FAIL reg_3p1: got sum_q=%0d co_q=%0b want 4 0", sum_q, co_q);
    end
    a = 4'd6; ci = 1'b1;
    tick();
    total++;
    if (sum_q !== 4'd0 || co_q !== 1'b1) begin
      bad++; $display("FAIL reg_6p1: got sum_q=%0d co_q=%0b want 0 1", sum_q, co_q);
    end
  endtask

  task automatic test_err();
    rst_n = 1'b0; a = 4'd0; ci = 1'b0; tick();
    rst_n = 1'b1; a = 4'd9; tick();
    total++;
    if (err !== 1'(ERR_EN)) begin
      bad++; $display("FAIL err_set: got err=%0b want %0d", err, ERR_EN);
    end
    a = 4'd2; tick(); tick();
    total++;
    if (err !== 1'(ERR_EN)) begin
      bad++; $display("FAIL err_sticky: got err=%0b want %0d", err, ERR_EN);
    end
    rst_n = 1'b0; tick();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL err_clear: got err=%0b want 0", err);
    end
    // reset wins over a simultaneous out-of-range sample
    a = 4'd12; tick();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL err_rst_prio: got err=%0b want 0", err);
    end
    rst_n = 1'b1; a = 4'd1; tick();
    chk_reg("err_release");
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      a     = N'($urandom_range(0, 15));
      ci    = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 15) != 0);
      #1;
      chk_comb("rand");
      tick();
      chk_reg("rand");
    end
  endtask

  initial begin
    exp_sq = 0; exp_cq = 0; exp_err = 0;
    test_reset();
    test_sweep();
    test_boundary();
    test_registered();
    test_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
